// File: rtl/uart_pkg.sv
// Shared widths and sizes for the UART transmit FIFO.
package uart_pkg;

  // Byte width carried by the UART datapath.
  localparam int UART_DATA_WIDTH    = 8;
  // Transmit FIFO pointer width.
  localparam int UART_TX_FIFO_AW    = 4;
  // Transmit FIFO depth in bytes.
  localparam int UART_TX_FIFO_DEPTH = 2 ** UART_TX_FIFO_AW;

endpackage : uart_pkg

// File: rtl/uart_fifo_ram.sv
// Storage array for the transmit FIFO: synchronous write, combinational read.
// Contents are intentionally not reset; the pointer/count logic in the parent
// decides which entries are meaningful.
module uart_fifo_ram
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int ADDR_WIDTH = UART_TX_FIFO_AW
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

  // Store the incoming byte at the write pointer when the write is accepted.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Head-of-queue byte is visible without a clock so a pop can latch it directly.
  assign o_rdata = r_mem[i_raddr];

endmodule : uart_fifo_ram

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO between the APB TX-data register and the UART transmitter.
// Holds pointers, occupancy counter, registered status flags, the sticky
// overflow flag and the output byte register; storage lives in uart_fifo_ram.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int ADDR_WIDTH = UART_TX_FIFO_AW
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  fifo_read_tx,
  input  logic                  clr_overflow,
  output logic [DATA_WIDTH-1:0] tx_dout_reg,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic [ADDR_WIDTH:0]   fifo_count,
  output logic                  overflow
);

  localparam logic [ADDR_WIDTH:0]   ZERO_COUNT = {(ADDR_WIDTH + 1){1'b0}};
  localparam logic [ADDR_WIDTH:0]   ONE_COUNT  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH-1:0] ZERO_PTR   = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ONE_PTR    = {{(ADDR_WIDTH - 1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] ZERO_BYTE  = {DATA_WIDTH{1'b0}};

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;

  logic                  w_pop;
  logic                  w_wr;
  logic                  w_ovf_set;
  logic [ADDR_WIDTH:0]   w_count_next;
  logic [DATA_WIDTH-1:0] w_rdata;

  uart_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr),
    .i_waddr (r_wr_ptr),
    .i_wdata (wr_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  // Decide which requests are accepted this cycle. A pop on an empty FIFO is
  // ignored even if a write arrives in the same cycle (no fall-through); a
  // write to a full FIFO only goes in when a pop frees a slot on the same edge.
  always_comb begin
    w_pop     = 1'b0;
    w_wr      = 1'b0;
    w_ovf_set = 1'b0;
    if ((fifo_read_tx == 1'b0) && (r_count != ZERO_COUNT)) begin
      w_pop = 1'b1;
    end else begin
      w_pop = 1'b0;
    end
    if ((wr_en == 1'b1) && ((r_count != FULL_COUNT) || (w_pop == 1'b1))) begin
      w_wr = 1'b1;
    end else begin
      w_wr = 1'b0;
    end
    w_ovf_set = wr_en & ~w_wr;
  end

  // Next occupancy: simultaneous write and pop leave the count unchanged.
  always_comb begin
    w_count_next = r_count;
    case ({w_wr, w_pop})
      2'b10:   w_count_next = r_count + ONE_COUNT;
      2'b01:   w_count_next = r_count - ONE_COUNT;
      default: w_count_next = r_count;
    endcase
  end

  // Pointers, counter, status flags and output byte, all on one edge so the
  // flags always agree with the count seen by the status register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr    <= ZERO_PTR;
      r_rd_ptr    <= ZERO_PTR;
      r_count     <= ZERO_COUNT;
      fifo_empty  <= 1'b1;
      fifo_full   <= 1'b0;
      tx_dout_reg <= ZERO_BYTE;
      overflow    <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + ONE_PTR;
      end
      if (w_pop) begin
        r_rd_ptr    <= r_rd_ptr + ONE_PTR;
        tx_dout_reg <= w_rdata;
      end
      r_count    <= w_count_next;
      fifo_empty <= (w_count_next == ZERO_COUNT);
      fifo_full  <= (w_count_next == FULL_COUNT);
      // A new overflow event wins over a clear arriving in the same cycle.
      if (w_ovf_set) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

  assign fifo_count = r_count;

endmodule : uart_tx_fifo

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed scenarios plus randomized
// traffic, compared every cycle against a queue-based reference model.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int DEPTH = UART_TX_FIFO_DEPTH;

  logic       clk;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       fifo_read_tx;
  logic       clr_overflow;
  logic [7:0] tx_dout_reg;
  logic       fifo_empty;
  logic       fifo_full;
  logic [4:0] fifo_count;
  logic       overflow;

  int n_vec;
  int n_err;

  // Reference model state: the stored bytes in order, the last popped byte and
  // the sticky overflow flag.
  logic [7:0] m_q[$];
  logic [7:0] m_dout;
  logic       m_ovf;

  uart_tx_fifo dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .fifo_read_tx (fifo_read_tx),
    .clr_overflow (clr_overflow),
    .tx_dout_reg  (tx_dout_reg),
    .fifo_empty   (fifo_empty),
    .fifo_full    (fifo_full),
    .fifo_count   (fifo_count),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string ctx);
    check_val({ctx, ".dout"},  {24'd0, tx_dout_reg}, {24'd0, m_dout});
    check_val({ctx, ".count"}, {27'd0, fifo_count}, 32'(m_q.size()));
    check_val({ctx, ".empty"}, {31'd0, fifo_empty}, {31'd0, (m_q.size() == 0)});
    check_val({ctx, ".full"},  {31'd0, fifo_full},  {31'd0, (m_q.size() == DEPTH)});
    check_val({ctx, ".ovf"},   {31'd0, overflow},   {31'd0, m_ovf});
  endtask

  // One clock cycle of stimulus: drive at the falling edge, let the model
  // apply the same request, then compare after the next falling edge.
  task automatic step(input string ctx, input bit wr, input logic [7:0] d,
                      input bit rd_n, input bit clr);
    bit pop_ok;
    bit wr_ok;
    wr_en        = wr;
    wr_data      = d;
    fifo_read_tx = rd_n;
    clr_overflow = clr;
    pop_ok = (rd_n == 1'b0) && (m_q.size() > 0);
    wr_ok  = wr && ((m_q.size() < DEPTH) || pop_ok);
    if (pop_ok) m_dout = m_q.pop_front();
    if (wr_ok) m_q.push_back(d);
    if (wr && !wr_ok) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_all(ctx);
  endtask

  task automatic idle(input string ctx);
    step(ctx, 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic do_reset(input string ctx);
    wr_en        = 1'b0;
    wr_data      = 8'h00;
    fifo_read_tx = 1'b1;
    clr_overflow = 1'b0;
    reset        = 1'b1;
    m_q.delete();
    m_dout = 8'h00;
    m_ovf  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_all(ctx);
    reset = 1'b0;
  endtask

  initial begin
    n_vec        = 0;
    n_err        = 0;
    reset        = 1'b1;
    wr_en        = 1'b0;
    wr_data      = 8'h00;
    fifo_read_tx = 1'b1;
    clr_overflow = 1'b0;
    m_dout       = 8'h00;
    m_ovf        = 1'b0;
    @(negedge clk);

    // Reset then idle.
    do_reset("rst");
    for (int i = 0; i < 5; i++) idle("idle");

    // Single byte through.
    step("wrA5", 1'b1, 8'hA5, 1'b1, 1'b0);
    step("popA5", 1'b0, 8'h00, 1'b0, 1'b0);
    check_val("a5_out", {24'd0, tx_dout_reg}, 32'h0000_00A5);

    // Fill, overflow, drain in order.
    for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, 8'(i), 1'b1, 1'b0);
    step("ovf_wr", 1'b1, 8'h10, 1'b1, 1'b0);
    check_val("ovf_set", {31'd0, overflow}, 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      step("drain", 1'b0, 8'h00, 1'b0, 1'b0);
      check_val("drain_order", {24'd0, tx_dout_reg}, 32'(i));
    end
    step("pop_empty", 1'b0, 8'h00, 1'b0, 1'b0);
    step("clr_ovf", 1'b0, 8'h00, 1'b1, 1'b1);

    // Full FIFO with simultaneous write and pop.
    for (int i = 0; i < DEPTH; i++) step("fill2", 1'b1, 8'(8'h80 + i), 1'b1, 1'b0);
    step("full_wrpop", 1'b1, 8'h55, 1'b0, 1'b0);
    check_val("full_head", {24'd0, tx_dout_reg}, 32'h0000_0080);
    for (int i = 0; i < DEPTH; i++) step("drain2", 1'b0, 8'h00, 1'b0, 1'b0);
    check_val("last_55", {24'd0, tx_dout_reg}, 32'h0000_0055);

    // Empty FIFO with simultaneous write and pop: no fall-through.
    step("empty_wrpop", 1'b1, 8'h3C, 1'b0, 1'b0);
    step("pop3C", 1'b0, 8'h00, 1'b0, 1'b0);

    // Overflow set and clear in the same cycle: set wins.
    for (int i = 0; i < DEPTH; i++) step("fill3", 1'b1, 8'($urandom), 1'b1, 1'b0);
    step("ovf_vs_clr", 1'b1, 8'hEE, 1'b1, 1'b1);

    // Partial load, reset mid-operation, then random traffic.
    do_reset("rst2");
    for (int i = 0; i < 8; i++) step("load8", 1'b1, 8'($urandom), 1'b1, 1'b0);
    do_reset("rst_mid");
    step("pop_after_rst", 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++)
      step("rand20", 1'($urandom), 8'($urandom), 1'($urandom), 1'b0);

    // Longer randomized traffic with phases biased toward filling and draining.
    for (int i = 0; i < 400; i++) begin
      bit fill_phase;
      bit wr;
      bit rd_n;
      fill_phase = ((i / 50) % 2) == 0;
      wr   = fill_phase ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      rd_n = fill_phase ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      step("rand", wr, 8'($urandom), rd_n, ($urandom_range(0, 7) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_uart_tx_fifo
